// File: rtl/snake_pkg.sv
// Shared snake-game direction encoding and helpers.
package snake_pkg;
  localparam int DIR_W = 5;

  localparam logic [DIR_W-1:0] DIR_UP    = 5'b00001;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 5'b00010;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 5'b00100;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 5'b01000;
  localparam logic [DIR_W-1:0] DIR_STOP  = 5'b10000;

  // STOP has no opposite; mapping it to itself keeps it from ever matching a real press.
  function automatic logic [DIR_W-1:0] opposite_dir(input logic [DIR_W-1:0] d);
    case (d)
      DIR_UP:    opposite_dir = DIR_DOWN;
      DIR_DOWN:  opposite_dir = DIR_UP;
      DIR_LEFT:  opposite_dir = DIR_RIGHT;
      DIR_RIGHT: opposite_dir = DIR_LEFT;
      default:   opposite_dir = DIR_STOP;
    endcase
  endfunction
endpackage

// File: rtl/button_debounce.sv
// Synchroniser + stability counter for one raw button; emits a one-cycle press pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic in_clk,
  input  logic in_rst_n,
  input  logic in_button,
  output logic out_press
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]       r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_last;
  logic             w_flip;

  assign w_diff = r_sync[1] ^ r_level;
  assign w_last = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign w_flip = w_diff & w_last;
  // Pulse coincides with the cycle whose edge commits the new high level.
  assign out_press = w_flip & ~r_level;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], in_button};
      r_level <= r_level ^ w_flip;
      if (!w_diff || w_last) r_cnt <= '0;
      else                   r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/direction_queue.sv
// Debounced button presses filtered against the last pending turn and queued;
// one queued turn is applied per game tick.
module direction_queue #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int QUEUE_DEPTH     = 4,
  parameter int DIR_W           = snake_pkg::DIR_W
) (
  input  logic                             in_clk,
  input  logic                             in_rst_n,
  input  logic                             in_button_up,
  input  logic                             in_button_down,
  input  logic                             in_button_left,
  input  logic                             in_button_right,
  input  logic                             in_clear,
  input  logic                             in_tick,
  output logic [DIR_W-1:0]                 out_direction,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] out_pending,
  output logic                             out_overflow
);
  import snake_pkg::*;

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [3:0]       w_raw;
  logic [3:0]       w_press;
  logic [DIR_W-1:0] r_q [QUEUE_DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic [DIR_W-1:0] r_dir;
  logic             r_ovf;
  logic [DIR_W-1:0] w_cand;
  logic [DIR_W-1:0] w_ref;
  logic [PW-1:0]    w_tail;
  logic             w_accept;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_raw = {in_button_right, in_button_left, in_button_down, in_button_up};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .in_clk    (in_clk),
      .in_rst_n  (in_rst_n),
      .in_button (w_raw[g]),
      .out_press (w_press[g])
    );
  end

  always_comb begin
    w_cand = DIR_STOP;
    if      (w_press[0]) w_cand = DIR_UP;
    else if (w_press[1]) w_cand = DIR_DOWN;
    else if (w_press[2]) w_cand = DIR_LEFT;
    else if (w_press[3]) w_cand = DIR_RIGHT;
  end

  // Compare against the most recently queued turn so double-turns chain correctly.
  assign w_tail   = r_wptr - PW'(1);
  assign w_ref    = (r_cnt != '0) ? r_q[w_tail] : r_dir;
  assign w_accept = (|w_press) && (w_cand != w_ref) && (w_cand != opposite_dir(w_ref));
  assign w_full   = (r_cnt == CW'(QUEUE_DEPTH));
  assign w_push   = w_accept && !w_full;
  assign w_pop    = in_tick && (r_cnt != '0);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) r_q[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_dir  <= DIR_STOP;
      r_ovf  <= 1'b0;
    end else if (in_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_dir  <= DIR_STOP;
      r_ovf  <= 1'b0;
    end else begin
      r_ovf <= w_accept && w_full;
      if (w_push) begin
        r_q[r_wptr] <= w_cand;
        r_wptr      <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_dir  <= r_q[r_rptr];
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign out_direction = r_dir;
  assign out_pending   = r_cnt;
  assign out_overflow  = r_ovf;
endmodule

// File: doc/direction_queue.md
Name: direction_queue

Overview:
Parametrised successor to the combinational direction decoder for the snake game. It debounces the four direction buttons and edge-detects them. Accepted presses are queued in a small FIFO of pending turns, and one turn is applied per game tick. Sits between the button pins and the snake movement/game-state logic. It replaces direct button-to-direction decoding so that fast double-turns are not lost and illegal 180-degree reversals are rejected.

Parameters:
DEBOUNCE_CYCLES, 16, number of consecutive stable samples required before a button level is accepted (minimum 1)
QUEUE_DEPTH, 4, number of pending turn entries held (power of two, minimum 2)
DIR_W, 5, width of the one-hot direction code

Ports:
in_clk  input  1  system clock
in_rst_n  input  1  asynchronous active-low reset
in_button_up  input  1  raw up button, active-high, asynchronous to in_clk
in_button_down  input  1  raw down button
in_button_left  input  1  raw left button
in_button_right  input  1  raw right button
in_clear  input  1  synchronous flush: empty the queue and force STOP
in_tick  input  1  single-cycle game-step strobe; consume one queued turn
out_direction  output  DIR_W  current applied direction, one-hot
out_pending  output  $clog2(QUEUE_DEPTH+1)  number of queued turns
out_overflow  output  1  single-cycle pulse when an accepted press is dropped because the queue is full

Behaviour:
- Encoding (one-hot): UP=5'b00001, DOWN=5'b00010, LEFT=5'b00100, RIGHT=5'b01000, STOP=5'b10000.
- Reset (in_rst_n low, asynchronous): out_direction=STOP, queue empty, out_pending=0, out_overflow=0, debounce counters=0, debounced levels=0.
- Input path:
  - Each button passes through a 2-flop synchroniser.
  - Then a debounce counter: the debounced level changes only after DEBOUNCE_CYCLES consecutive synchronised samples differ from the current level. Any matching sample resets the counter to 0.
  - A press event is a 0->1 transition of the debounced level, one cycle wide.
  - Latency from a stable raw edge to the press event is 2+DEBOUNCE_CYCLES cycles.
- Simultaneous press events in one cycle: only the highest-priority one is considered (UP > DOWN > LEFT > RIGHT). The others are discarded.
- Reference direction for a candidate press:
  - the tail entry of the queue if the queue is non-empty at the start of the cycle;
  - otherwise out_direction at the start of the cycle.
- Acceptance:
  - reject if the candidate equals the reference (duplicate);
  - reject if the candidate is the opposite of the reference (UP/DOWN, LEFT/RIGHT);
  - if the reference is STOP, any direction is accepted.
  - Rejected presses have no side effect and raise no flag.
- Push: an accepted press is written at the tail if count<QUEUE_DEPTH. If the queue is full, it is dropped and out_overflow pulses high for one cycle.
- Pop: on in_tick with count>0, the head entry is loaded into out_direction on the next edge and count decrements. On in_tick with the queue empty, out_direction holds.
- Push and pop in the same cycle:
  - both take effect and count is unchanged;
  - the full check uses the pre-cycle count, so a push into a full queue during a pop is still dropped;
  - with the queue empty, push and tick together: the entry is queued, nothing is popped (pop sees empty).
- in_clear, synchronous, highest priority: count=0, out_direction=STOP, any same-cycle push and pop are ignored, out_overflow=0.
- Pointers: read/write pointers are $clog2(QUEUE_DEPTH) bits wide and wrap modulo QUEUE_DEPTH. The count is kept separately for the full/empty decisions.
- out_pending and out_direction are registered. No combinational path from the inputs to the outputs.

Decomposition:
- Shared package snake_pkg: direction one-hot constants (DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT, DIR_STOP), DIR_W, and an opposite-direction function.
- One sub-module, button_debounce (synchroniser + counter + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated four times.
- Queue and acceptance logic stay in direction_queue.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, QUEUE_DEPTH=2.
1. Reset asserted mid-operation with 2 entries queued -> out_direction=5'b10000, out_pending=0 immediately, without waiting for a clock edge.
2. Hold in_button_up high for 10 cycles from STOP, then one in_tick -> exactly one entry queued (out_pending=1) 6 cycles after the edge. After the tick, out_direction=5'b00001 and out_pending=0. A 3-cycle glitch on any button queues nothing.
3. From out_direction=UP, press DOWN, then LEFT, then LEFT again -> DOWN rejected (opposite) and the second LEFT rejected (duplicate). out_pending=1, and on tick out_direction=5'b00100.
4. From UP, press LEFT, then DOWN (valid against tail LEFT), then RIGHT with no ticks -> out_pending=2. RIGHT is dropped with a 1-cycle out_overflow pulse. Two ticks give LEFT then DOWN.
5. Queue full (2 entries) with a press event and in_tick in the same cycle -> pop occurs, press dropped, out_overflow=1, out_pending=1. With the queue empty, press and tick together -> out_pending=1, out_direction unchanged.
6. UP and RIGHT debounced in the same cycle from STOP -> only UP queued. Then in_clear together with in_tick -> out_direction=STOP, out_pending=0.
